// File: rtl/pablo_mem_ctrl_if.sv
// Pablo external memory bus: one req/ack transaction at a time.
// The controller drives the request side (master); the memory answers (slave).
interface pablo_mem_ctrl_if #(
    parameter int AW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/pablo_mem_ctrl.sv
// Data-memory controller between the darkmm data port and the pablo memory.
// Each core access becomes one req/ack transaction; the core is stalled via
// hlt until the result is available. Stuck transactions time out and
// out-of-range addresses are rejected locally, both raising a sticky error.
module pablo_mem_ctrl #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] daddr,
    input  logic [31:0] datao,
    input  logic        wr,
    input  logic        rd,
    input  logic [3:0]  be,
    output logic [31:0] datai,
    output logic        hlt,
    input  logic        err_clr,
    output logic        err,
    output logic [31:0] err_addr,
    pablo_mem_ctrl_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;

    logic request;
    logic in_range;
    logic accept;
    logic reject;
    logic ack_hit;
    logic timeout_hit;

    // The stall must drop in DONE without waiting for a register, so the core
    // sees completion in the very cycle the result is valid.
    assign request  = wr | rd;
    assign in_range = (daddr >> (AW + 2)) == 32'd0;
    assign hlt      = request & (state != DONE);

    // Next-state decode plus one-cycle strobes for the datapath registers.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        reject      = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (in_range) begin
                        accept     = 1'b1;
                        next_state = REQ;
                    end else begin
                        reject     = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    ack_hit    = 1'b1;
                    next_state = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request fields are captured once on accept and held through REQ; the
    // wait counter saturates rather than wrapping.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'h0;
            mem.mem_wdata <= 32'h0;
            cnt           <= 16'h0;
        end else if (accept) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= wr;
            mem.mem_addr  <= daddr[AW+1:2];
            mem.mem_be    <= wr ? be : 4'hF;
            mem.mem_wdata <= datao;
            cnt           <= 16'h0;
        end else if (state == REQ) begin
            if (ack_hit || timeout_hit) begin
                mem.mem_req <= 1'b0;
            end
            if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'h1;
            end
        end
    end

    // Read data returned to the core; failed accesses return all ones and
    // completed writes leave the previous value in place.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            datai <= 32'h0;
        end else if (reject || timeout_hit) begin
            datai <= 32'hFFFF_FFFF;
        end else if (ack_hit && !mem.mem_we) begin
            datai <= mem.mem_rdata;
        end
    end

    // Sticky error status; a new error in the same cycle beats a clear.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            err      <= 1'b0;
            err_addr <= 32'h0;
        end else if (reject || timeout_hit) begin
            err      <= 1'b1;
            err_addr <= daddr;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pablo_mem_ctrl.sv
// Self-checking bench for pablo_mem_ctrl: directed vector table, reset
// corner cases, then randomized transactions against a transaction-level model.
module tb_pablo_mem_ctrl;

    localparam int AW      = 16;
    localparam int TIMEOUT = 6;

    logic        clk;
    logic        res;
    logic [31:0] daddr;
    logic [31:0] datao;
    logic        wr;
    logic        rd;
    logic [3:0]  be;
    logic [31:0] datai;
    logic        hlt;
    logic        err_clr;
    logic        err;
    logic [31:0] err_addr;

    pablo_mem_ctrl_if #(.AW(AW)) mem_bus ();

    pablo_mem_ctrl #(
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .res      (res),
        .daddr    (daddr),
        .datao    (datao),
        .wr       (wr),
        .rd       (rd),
        .be       (be),
        .datai    (datai),
        .hlt      (hlt),
        .err_clr  (err_clr),
        .err      (err),
        .err_addr (err_addr),
        .mem      (mem_bus.master)
    );

    typedef struct {
        logic          wr;
        logic          rd;
        logic [31:0]   daddr;
        logic [3:0]    be;
        logic [31:0]   datao;
        logic [31:0]   rdata;
        int            ack_cycle;
        logic          clr_before;
        int            exp_done;
        logic [31:0]   exp_datai;
        logic          exp_err;
        logic [31:0]   exp_err_addr;
        logic [AW-1:0] exp_mem_addr;
        logic [3:0]    exp_mem_be;
        logic          exp_we;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_datai;
    logic        m_err;
    logic [31:0] m_err_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t make_vec(
        input logic wr_i, input logic rd_i, input logic [31:0] addr_i,
        input logic [3:0] be_i, input logic [31:0] wdata_i, input logic [31:0] rdata_i,
        input int ack_i, input logic clr_i, input int done_i,
        input logic [31:0] datai_i, input logic err_i, input logic [31:0] err_addr_i,
        input logic [AW-1:0] maddr_i, input logic [3:0] mbe_i, input logic we_i);
        vec_t v;
        v.wr = wr_i;           v.rd = rd_i;            v.daddr = addr_i;
        v.be = be_i;           v.datao = wdata_i;      v.rdata = rdata_i;
        v.ack_cycle = ack_i;   v.clr_before = clr_i;   v.exp_done = done_i;
        v.exp_datai = datai_i; v.exp_err = err_i;      v.exp_err_addr = err_addr_i;
        v.exp_mem_addr = maddr_i; v.exp_mem_be = mbe_i; v.exp_we = we_i;
        return v;
    endfunction

    // Transaction-level model: decides the outcome of a whole access from
    // the address range, the ack cycle and the timeout limit.
    task automatic predict(inout vec_t v);
        logic [63:0] limit;
        logic        oor;
        logic        acked;
        limit = 64'd1 << (AW + 2);
        oor   = {32'd0, v.daddr} >= limit;
        acked = !oor && (v.ack_cycle >= 1) && (v.ack_cycle <= TIMEOUT);
        if (v.clr_before) m_err = 1'b0;
        if (oor)        v.exp_done = 1;
        else if (acked) v.exp_done = v.ack_cycle + 1;
        else            v.exp_done = TIMEOUT + 1;
        if (!acked) begin
            m_datai    = 32'hFFFF_FFFF;
            m_err      = 1'b1;
            m_err_addr = v.daddr;
        end else if (!v.wr) begin
            m_datai = v.rdata;
        end
        v.exp_datai    = m_datai;
        v.exp_err      = m_err;
        v.exp_err_addr = m_err_addr;
        v.exp_mem_addr = AW'((v.daddr / 4) % (32'd1 << AW));
        v.exp_mem_be   = v.wr ? v.be : 4'hF;
        v.exp_we       = v.wr;
    endtask

    // Drives one core access cycle by cycle and checks the bus and result.
    task automatic apply_stimulus(input vec_t v);
        if (v.clr_before) begin
            @(posedge clk); #1 err_clr = 1'b1;
            @(posedge clk); #1 err_clr = 1'b0;
            @(negedge clk);
            check1("err_clr", err, 1'b0);
        end
        @(posedge clk); #1;
        wr = v.wr; rd = v.rd; daddr = v.daddr; be = v.be; datao = v.datao;
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        check1("hlt_c0", hlt, 1'b1);
        check1("req_c0", mem_bus.mem_req, 1'b0);
        for (int c = 1; c <= v.exp_done; c++) begin
            @(posedge clk); #1;
            mem_bus.mem_ack   = (c == v.ack_cycle);
            mem_bus.mem_rdata = v.rdata;
            @(negedge clk);
            if (c < v.exp_done) begin
                check1("hlt_req", hlt, 1'b1);
                check1("mem_req", mem_bus.mem_req, 1'b1);
                check32("mem_addr", 32'(mem_bus.mem_addr), 32'(v.exp_mem_addr));
                check32("mem_be", 32'(mem_bus.mem_be), 32'(v.exp_mem_be));
                check1("mem_we", mem_bus.mem_we, v.exp_we);
                if (v.wr) check32("mem_wdata", mem_bus.mem_wdata, v.datao);
            end else begin
                check_output(v);
            end
        end
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        check1("hlt_idle", hlt, 1'b0);
    endtask

    // Checks the DONE cycle of an access.
    task automatic check_output(input vec_t v);
        check1("hlt_done", hlt, 1'b0);
        check1("req_done", mem_bus.mem_req, 1'b0);
        check32("datai", datai, v.exp_datai);
        check1("err", err, v.exp_err);
        check32("err_addr", err_addr, v.exp_err_addr);
    endtask

    vec_t table_v[10];
    vec_t v;
    vec_t scratch;

    initial begin
        res = 1'b1; wr = 1'b0; rd = 1'b0; daddr = 32'h0; datao = 32'h0;
        be = 4'h0; err_clr = 1'b0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
        m_datai = 32'h0; m_err = 1'b0; m_err_addr = 32'h0;

        //               wr    rd    daddr          be     datao          rdata          ack clr done datai          err  err_addr       maddr     mbe    we
        table_v[0] = make_vec(1'b0, 1'b1, 32'h0000_0010, 4'h0, 32'h0,         32'hCAFE_0001, 1, 1'b0, 2, 32'hCAFE_0001, 1'b0, 32'h0,         16'h0004, 4'hF, 1'b0);
        table_v[1] = make_vec(1'b1, 1'b0, 32'h0000_0024, 4'h3, 32'h1234_5678, 32'h5555_5555, 5, 1'b0, 6, 32'hCAFE_0001, 1'b0, 32'h0,         16'h0009, 4'h3, 1'b1);
        table_v[2] = make_vec(1'b0, 1'b1, 32'h0000_0100, 4'h0, 32'h0,         32'h1111_1111, 0, 1'b0, 7, 32'hFFFF_FFFF, 1'b1, 32'h0000_0100, 16'h0040, 4'hF, 1'b0);
        table_v[3] = make_vec(1'b0, 1'b1, 32'h0000_0200, 4'h0, 32'h0,         32'hA5A5_0006, 6, 1'b1, 7, 32'hA5A5_0006, 1'b0, 32'h0000_0100, 16'h0080, 4'hF, 1'b0);
        table_v[4] = make_vec(1'b1, 1'b0, 32'h0004_0000, 4'hF, 32'h9999_9999, 32'h0,         1, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, 32'h0004_0000, 16'h0000, 4'h0, 1'b0);
        table_v[5] = make_vec(1'b1, 1'b0, 32'h0003_FFFC, 4'h8, 32'hDEAD_BEEF, 32'h2222_2222, 2, 1'b1, 3, 32'hFFFF_FFFF, 1'b0, 32'h0004_0000, 16'hFFFF, 4'h8, 1'b1);
        table_v[6] = make_vec(1'b1, 1'b1, 32'h0000_0008, 4'h5, 32'h0BAD_F00D, 32'h3333_3333, 3, 1'b0, 4, 32'hFFFF_FFFF, 1'b0, 32'h0004_0000, 16'h0002, 4'h5, 1'b1);
        table_v[7] = make_vec(1'b0, 1'b1, 32'hFFFF_FFF0, 4'h0, 32'h0,         32'h4444_4444, 1, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFF0, 16'h0000, 4'h0, 1'b0);
        table_v[8] = make_vec(1'b0, 1'b1, 32'h0000_0004, 4'h0, 32'h0,         32'h6666_6666, 7, 1'b1, 7, 32'hFFFF_FFFF, 1'b1, 32'h0000_0004, 16'h0001, 4'hF, 1'b0);
        table_v[9] = make_vec(1'b0, 1'b1, 32'h0000_000C, 4'h0, 32'h0,         32'h1357_9BDF, 1, 1'b1, 2, 32'h1357_9BDF, 1'b0, 32'h0000_0004, 16'h0003, 4'hF, 1'b0);

        repeat (2) @(negedge clk);
        check1("rst_mem_req", mem_bus.mem_req, 1'b0);
        check1("rst_mem_we", mem_bus.mem_we, 1'b0);
        check32("rst_mem_addr", 32'(mem_bus.mem_addr), 32'h0);
        check32("rst_mem_be", 32'(mem_bus.mem_be), 32'h0);
        check32("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
        check32("rst_datai", datai, 32'h0);
        check1("rst_err", err, 1'b0);
        check32("rst_err_addr", err_addr, 32'h0);
        check1("rst_hlt_idle", hlt, 1'b0);
        rd = 1'b1;
        #1 check1("rst_hlt_follows", hlt, 1'b1);
        rd = 1'b0;
        @(posedge clk); #1 res = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            scratch = table_v[i];
            predict(scratch);
            apply_stimulus(table_v[i]);
        end

        $display("[TB] reset during REQ");
        @(posedge clk); #1 rd = 1'b1; daddr = 32'h0000_0020;
        @(posedge clk); #1;
        @(negedge clk);
        check1("pre_rst_req", mem_bus.mem_req, 1'b1);
        @(posedge clk); #1 res = 1'b1;
        #1;
        check1("midrst_req", mem_bus.mem_req, 1'b0);
        check1("midrst_hlt", hlt, 1'b1);
        check32("midrst_datai", datai, 32'h0);
        check32("midrst_err_addr", err_addr, 32'h0);
        @(posedge clk); #1;
        res = 1'b0; rd = 1'b0;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hBADB_ADBA;
        @(negedge clk);
        check1("stale_hlt", hlt, 1'b0);
        check1("stale_req", mem_bus.mem_req, 1'b0);
        @(posedge clk); #1 mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        check32("stale_datai", datai, 32'h0);
        check1("stale_err", err, 1'b0);
        m_datai = 32'h0; m_err = 1'b0; m_err_addr = 32'h0;
        v = make_vec(1'b0, 1'b1, 32'h0000_0030, 4'h0, 32'h0, 32'h7777_1234, 2, 1'b0,
                     0, 32'h0, 1'b0, 32'h0, '0, 4'h0, 1'b0);
        predict(v);
        apply_stimulus(v);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 80; n++) begin
            int sel;
            sel = $urandom_range(0, 2);
            v.wr = (sel != 0);
            v.rd = (sel != 1);
            if ($urandom_range(0, 4) == 0) v.daddr = $urandom_range(32'h0004_0000, 32'hFFFF_FFFF);
            else                           v.daddr = $urandom % (32'd1 << (AW + 2));
            v.be         = 4'($urandom);
            v.datao      = $urandom;
            v.rdata      = $urandom;
            v.ack_cycle  = $urandom_range(0, TIMEOUT + 1);
            v.clr_before = 1'($urandom_range(0, 1));
            predict(v);
            apply_stimulus(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
